// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps note-on/off events onto voice slots with
// retrigger reuse and oldest-voice stealing, scanning one voice per cycle.
module voice_allocator #(
    parameter int unsigned NUM_VOICES  = 8,
    parameter int unsigned NOTE_WIDTH  = 7,
    parameter int unsigned INC_WIDTH   = 32,
    parameter int unsigned STAMP_WIDTH = 16
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic                                  note_valid_in,
    output logic                                  note_ready_out,
    input  logic                                  note_on_in,
    input  logic [NOTE_WIDTH-1:0]                 note_in,
    input  logic [INC_WIDTH-1:0]                  phase_inc_in,
    output logic [NUM_VOICES-1:0]                 gate_out,
    output logic [NUM_VOICES-1:0][INC_WIDTH-1:0]  phase_inc_out,
    output logic [NUM_VOICES-1:0][NOTE_WIDTH-1:0] voice_note_out,
    output logic [$clog2(NUM_VOICES):0]           num_active_out,
    output logic                                  steal_out,
    output logic                                  retrig_out
);

    localparam int unsigned IDX_W = $clog2(NUM_VOICES);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic                   accept;
    logic                   hold_on_q;
    logic [NOTE_WIDTH-1:0]  hold_note_q;
    logic [INC_WIDTH-1:0]   hold_inc_q;

    logic [IDX_W-1:0]       idx_q;
    logic                   match_found_q, free_found_q, old_found_q;
    logic [IDX_W-1:0]       match_idx_q, free_idx_q, old_idx_q;
    logic [STAMP_WIDTH-1:0] old_age_q;
    logic [STAMP_WIDTH-1:0] age;

    logic [NUM_VOICES-1:0][STAMP_WIDTH-1:0] stamp_q, stamp_d;
    logic [STAMP_WIDTH-1:0]                 alloc_q, alloc_d;

    logic [NUM_VOICES-1:0]                 gate_d;
    logic [NUM_VOICES-1:0][INC_WIDTH-1:0]  inc_d;
    logic [NUM_VOICES-1:0][NOTE_WIDTH-1:0] note_d;
    logic [CNT_W-1:0]                      cnt_d;
    logic                                  steal_d, retrig_d, ready_d;
    logic [IDX_W-1:0]                      tgt;

    assign accept = note_valid_in & note_ready_out;
    assign age    = alloc_q - stamp_q[idx_q];

    // State register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SCAN;
            SCAN:    if (idx_q == LAST_IDX) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Event capture and per-voice scan trackers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            hold_on_q     <= 1'b0;
            hold_note_q   <= '0;
            hold_inc_q    <= '0;
            idx_q         <= '0;
            match_found_q <= 1'b0;
            free_found_q  <= 1'b0;
            old_found_q   <= 1'b0;
            match_idx_q   <= '0;
            free_idx_q    <= '0;
            old_idx_q     <= '0;
            old_age_q     <= '0;
        end else if (accept) begin
            hold_on_q     <= note_on_in;
            hold_note_q   <= note_in;
            hold_inc_q    <= phase_inc_in;
            idx_q         <= '0;
            match_found_q <= 1'b0;
            free_found_q  <= 1'b0;
            old_found_q   <= 1'b0;
        end else if (state_q == SCAN) begin
            idx_q <= idx_q + 1'b1;
            if (gate_out[idx_q] && (voice_note_out[idx_q] == hold_note_q) && !match_found_q) begin
                match_found_q <= 1'b1;
                match_idx_q   <= idx_q;
            end
            if (!gate_out[idx_q] && !free_found_q) begin
                free_found_q <= 1'b1;
                free_idx_q   <= idx_q;
            end
            // Strict compare keeps the lower index on equal age
            if (gate_out[idx_q] && (!old_found_q || (age > old_age_q))) begin
                old_found_q <= 1'b1;
                old_idx_q   <= idx_q;
                old_age_q   <= age;
            end
        end
    end

    // Output logic: next values of all registered outputs
    always_comb begin
        gate_d   = gate_out;
        inc_d    = phase_inc_out;
        note_d   = voice_note_out;
        stamp_d  = stamp_q;
        alloc_d  = alloc_q;
        steal_d  = 1'b0;
        retrig_d = 1'b0;
        tgt      = '0;
        ready_d  = (state_d == IDLE);
        cnt_d    = '0;
        if (state_q == COMMIT) begin
            if (hold_on_q) begin
                if (match_found_q) begin
                    tgt      = match_idx_q;
                    retrig_d = 1'b1;
                end else if (free_found_q) begin
                    tgt = free_idx_q;
                end else begin
                    tgt     = old_idx_q;
                    steal_d = 1'b1;
                end
                gate_d[tgt]  = 1'b1;
                inc_d[tgt]   = hold_inc_q;
                note_d[tgt]  = hold_note_q;
                stamp_d[tgt] = alloc_q;
                alloc_d      = alloc_q + 1'b1;
            end else if (match_found_q) begin
                gate_d[match_idx_q] = 1'b0;
            end
        end
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            cnt_d = cnt_d + CNT_W'(gate_d[i]);
        end
    end

    // Output and voice-state registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            gate_out       <= '0;
            phase_inc_out  <= '0;
            voice_note_out <= '0;
            num_active_out <= '0;
            steal_out      <= 1'b0;
            retrig_out     <= 1'b0;
            note_ready_out <= 1'b0;
            stamp_q        <= '0;
            alloc_q        <= '0;
        end else begin
            gate_out       <= gate_d;
            phase_inc_out  <= inc_d;
            voice_note_out <= note_d;
            num_active_out <= cnt_d;
            steal_out      <= steal_d;
            retrig_out     <= retrig_d;
            note_ready_out <= ready_d;
            stamp_q        <= stamp_d;
            alloc_q        <= alloc_d;
        end
    end

endmodule
